video_addr_counter: RTL and testbench
=====================================

Name: video_addr_counter

Overview:
- Video DMA address generator downstream of the sync/DE generators.
- Consumes de and vsync_n and produces the word address and fetch request for each screen word that the shifter needs.
- Holds the video base registers (ff8201/03/0d), the live counter (ff8205/07/09), line-offset (ff820f) and hscroll (ff8265) registers, all CPU-accessible.
- STE features are gated by a parameter so the same block serves ST and STE builds.

Parameters:
- STE, 1, enables low base byte, counter writes, line offset and hscroll prefetch; 0 = plain ST behaviour.
- ADDR_W, 22, byte-address width; bit 0 is always 0.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- fetch  input  1  one-clk strobe marking each video word slot (from clockgen timing).
- de  input  1  display enable from hdegen/vdegen.
- vsync_n  input  1  active-low vertical sync.
- cpu_sel  input  1  CPU access to the ff82xx register window.
- cpu_addr  input  5  register address bits A5..A1.
- cpu_we  input  1  write strobe, one clk.
- cpu_din  input  8  write data (odd byte lane).
- cpu_dout  output  8  read data (combinational from registers).
- vid_addr  output  ADDR_W-1  current word address, bits [ADDR_W-1:1].
- vid_req  output  1  memory fetch request for vid_addr, one clk.

Behaviour:
- Reset: base, counter, linewid, hscroll = 0; vid_req = 0; vid_addr = 0; edge-detect flops = 1 (vsync_n) and 0 (de).
- Register map (cpu_addr):
  - 0x00 base[21:16]
  - 0x01 base[15:8]
  - 0x02 cnt[21:16]
  - 0x03 cnt[15:8]
  - 0x04 cnt[7:1]
  - 0x06 base[7:1] (STE)
  - 0x07 linewid[7:0] (STE)
  - 0x32 hscroll[3:0] (STE)
- Unused bits read 0; other addresses read 0xFF.
- If STE=0: writes to 0x06/0x07/0x32 and to the counter are ignored. base[7:1] reads 0 and is forced 0, and any write to 0x00/0x01 clears base[7:1] (ST rule).
- Counter step: when fetch=1 and (de=1 or prefetch_pending=1), vid_req=1 in the same clk and cnt += 2 at the clk edge. vid_addr shows the pre-increment value during the request.
- Prefetch (STE, hscroll != 0): on a de rising edge, set prefetch_pending. The next fetch generates one extra word and clears it. prefetch_pending is cleared at vsync reload.
- End of line: on a de falling edge (registered de=1, de=0), cnt += linewid*2 (zero-extended, modulo 2^ADDR_W).
- Frame reload: on a vsync_n falling edge, cnt <= base.
- Counter arithmetic wraps modulo 2^ADDR_W; bit 0 is held 0.
- Priority in one clk: vsync reload > CPU counter-byte write > end-of-line add > fetch increment. The losing updates are dropped, not deferred.
- A CPU byte write to the counter replaces only that byte; the other bytes keep their pre-increment value.
- vid_req is still asserted on a cycle where the increment is dropped.
- Base writes never affect cnt until the next reload.
- Asynchronous reset mid-line clears all state immediately. The first reload occurs at the next vsync_n fall.

Test Plan:
- Reset, write base=0x078000 (0x07, 0x80, 0x00), pulse vsync_n low -> counter reads 0x078000; 0x00/0x01 read back 0x07/0x80.
- de=1 for 80 fetch strobes after reload -> 80 vid_req pulses with vid_addr 0x078000…0x07809E (word address = byte/2); counter = 0x0780A0 after de falls.
- STE, linewid=4: at de fall, counter 0x0780A0 -> 0x0780A8; next line starts at 0x0780A8.
- STE, hscroll=5: de rises -> 81 requests on the line, counter advances by 0xA2.
- vsync_n fall and fetch with de=1 in the same clk -> counter = base; vid_req still asserted; no +2.
- STE=0: write 0x55 to 0x06 and 0x12 to 0x04 -> reads 0 and the counter is unchanged. Assert reset mid-line -> vid_req=0 and all registers 0 on the next read.

Source files
------------

// File: rtl/video_addr_counter.sv
// Video DMA word-address generator: base/counter/line-offset/hscroll registers
// plus the per-slot fetch request that feeds the shifter.
module video_addr_counter #(
  parameter bit STE    = 1'b1,
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch,
  input  logic              de,
  input  logic              vsync_n,
  input  logic              cpu_sel,
  input  logic [4:0]        cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic [ADDR_W-2:0] vid_addr,
  output logic              vid_req
);

  // Counter and base are held as word addresses; byte bit 0 is implicitly 0.
  localparam int WA   = ADDR_W - 1;
  localparam int HI_W = ADDR_W - 16;

  localparam logic [4:0] A_BASE_HI  = 5'h00;
  localparam logic [4:0] A_BASE_MID = 5'h01;
  localparam logic [4:0] A_CNT_HI   = 5'h02;
  localparam logic [4:0] A_CNT_MID  = 5'h03;
  localparam logic [4:0] A_CNT_LO   = 5'h04;
  localparam logic [4:0] A_BASE_LO  = 5'h06;
  localparam logic [4:0] A_LINEWID  = 5'h07;
  // hscroll sits at word offset 0x32; only A5..A1 reach this block, so it decodes as 0x12.
  localparam logic [4:0] A_HSCROLL  = 5'h12;

  logic [WA-1:0]   cnt_reg, cnt_next;
  logic [HI_W-1:0] base_hi_reg;
  logic [7:0]      base_mid_reg;
  logic [6:0]      base_lo;
  logic [7:0]      linewid;
  logic [3:0]      hscroll;
  logic            pending_reg, pending_next;
  logic            vsync_q_reg, de_q_reg;

  logic vsync_fall, de_rise, de_fall, cpu_wr, cnt_wr, req;
  logic [WA-1:0] base_word;

  assign vsync_fall = vsync_q_reg & ~vsync_n;
  assign de_rise    = ~de_q_reg & de;
  assign de_fall    = de_q_reg & ~de;
  assign cpu_wr     = cpu_sel & cpu_we;
  assign cnt_wr     = STE && cpu_wr &&
                      (cpu_addr == A_CNT_HI || cpu_addr == A_CNT_MID || cpu_addr == A_CNT_LO);
  assign req        = fetch & (de | pending_reg);
  assign base_word  = {base_hi_reg, base_mid_reg, base_lo};

  assign vid_addr = cnt_reg;
  assign vid_req  = req & ~reset;

  generate
    if (STE) begin : g_ste
      logic [6:0] base_lo_reg;
      logic [7:0] linewid_reg;
      logic [3:0] hscroll_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          base_lo_reg <= '0;
          linewid_reg <= '0;
          hscroll_reg <= '0;
        end else if (cpu_wr) begin
          case (cpu_addr)
            A_BASE_LO: base_lo_reg <= cpu_din[7:1];
            A_LINEWID: linewid_reg <= cpu_din;
            A_HSCROLL: hscroll_reg <= cpu_din[3:0];
            default: ;
          endcase
        end
      end

      assign base_lo = base_lo_reg;
      assign linewid = linewid_reg;
      assign hscroll = hscroll_reg;
    end else begin : g_st
      // Plain ST: low base byte is hardwired 0, so high/mid writes always leave it clear.
      assign base_lo = '0;
      assign linewid = '0;
      assign hscroll = '0;
    end
  endgenerate

  // Only one counter update per clock; lower-priority updates are lost.
  always_comb begin
    cnt_next = cnt_reg;
    if (vsync_fall) begin
      cnt_next = base_word;
    end else if (cnt_wr) begin
      case (cpu_addr)
        A_CNT_HI:  cnt_next[WA-1:15] = cpu_din[HI_W-1:0];
        A_CNT_MID: cnt_next[14:7]    = cpu_din;
        default:   cnt_next[6:0]     = cpu_din[7:1];
      endcase
    end else if (de_fall) begin
      cnt_next = cnt_reg + WA'(linewid);
    end else if (req) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // The prefetch word is taken by the first slot that de itself does not cover.
  always_comb begin
    pending_next = pending_reg;
    if (vsync_fall)
      pending_next = 1'b0;
    else if (de_rise && hscroll != 4'd0)
      pending_next = 1'b1;
    else if (fetch && !de)
      pending_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg      <= '0;
      base_hi_reg  <= '0;
      base_mid_reg <= '0;
      pending_reg  <= 1'b0;
      vsync_q_reg  <= 1'b1;
      de_q_reg     <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      vsync_q_reg <= vsync_n;
      de_q_reg    <= de;
      if (cpu_wr && cpu_addr == A_BASE_HI)  base_hi_reg  <= cpu_din[HI_W-1:0];
      if (cpu_wr && cpu_addr == A_BASE_MID) base_mid_reg <= cpu_din;
    end
  end

  always_comb begin
    cpu_dout = 8'hFF;
    case (cpu_addr)
      A_BASE_HI: begin
        cpu_dout = '0;
        cpu_dout[HI_W-1:0] = base_hi_reg;
      end
      A_BASE_MID: cpu_dout = base_mid_reg;
      A_CNT_HI: begin
        cpu_dout = '0;
        cpu_dout[HI_W-1:0] = cnt_reg[WA-1:15];
      end
      A_CNT_MID: cpu_dout = cnt_reg[14:7];
      A_CNT_LO:  cpu_dout = {cnt_reg[6:0], 1'b0};
      A_BASE_LO: cpu_dout = {base_lo, 1'b0};
      A_LINEWID: cpu_dout = linewid;
      A_HSCROLL: cpu_dout = {4'b0000, hscroll};
      default:   cpu_dout = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_video_addr_counter.sv
// Scoreboard bench for video_addr_counter: STE and plain-ST instances,
// expected request addresses and read bytes queued by the stimulus, popped by a monitor.
module tb_video_addr_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch, de, vsync_n, cpu_sel, cpu_we;
  logic [4:0]  cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic [20:0] vid_addr;
  logic        vid_req;

  logic        st_vsync_n, st_cpu_sel, st_cpu_we;
  logic [4:0]  st_cpu_addr;
  logic [7:0]  st_cpu_din;
  logic [7:0]  st_cpu_dout;
  logic [20:0] st_vid_addr;
  logic        st_vid_req;

  int tests  = 0;
  int failed = 0;

  logic [20:0] addr_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  st_rd_q[$];

  video_addr_counter #(.STE(1'b1), .ADDR_W(22)) dut (
    .clk(clk), .reset(reset), .fetch(fetch), .de(de), .vsync_n(vsync_n),
    .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .vid_addr(vid_addr), .vid_req(vid_req)
  );

  video_addr_counter #(.STE(1'b0), .ADDR_W(22)) dut_st (
    .clk(clk), .reset(reset), .fetch(1'b0), .de(1'b0), .vsync_n(st_vsync_n),
    .cpu_sel(st_cpu_sel), .cpu_addr(st_cpu_addr), .cpu_we(st_cpu_we), .cpu_din(st_cpu_din),
    .cpu_dout(st_cpu_dout), .vid_addr(st_vid_addr), .vid_req(st_vid_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: pops an expectation whenever a DUT presents a request or a read.
  always @(negedge clk) begin
    if (vid_req) begin
      if (addr_q.size() == 0) check("ste_unexpected_req", {11'd0, vid_addr}, 32'hFFFF_FFFF);
      else check("ste_vid_addr", {11'd0, vid_addr}, {11'd0, addr_q.pop_front()});
    end
    if (cpu_sel && !cpu_we) begin
      if (rd_q.size() == 0) check("ste_unexpected_read", {24'd0, cpu_dout}, 32'hFFFF_FFFF);
      else check($sformatf("ste_read_%02h", cpu_addr), {24'd0, cpu_dout}, {24'd0, rd_q.pop_front()});
    end
    if (st_vid_req) check("st_unexpected_req", {11'd0, st_vid_addr}, 32'hFFFF_FFFF);
    if (st_cpu_sel && !st_cpu_we) begin
      if (st_rd_q.size() == 0) check("st_unexpected_read", {24'd0, st_cpu_dout}, 32'hFFFF_FFFF);
      else check($sformatf("st_read_%02h", st_cpu_addr), {24'd0, st_cpu_dout}, {24'd0, st_rd_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    tick();
    cpu_sel = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    tick();
    cpu_sel = 1'b0;
  endtask

  task automatic st_wr(input logic [4:0] a, input logic [7:0] d);
    st_cpu_sel = 1'b1; st_cpu_we = 1'b1; st_cpu_addr = a; st_cpu_din = d;
    tick();
    st_cpu_sel = 1'b0; st_cpu_we = 1'b0;
  endtask

  task automatic st_rd(input logic [4:0] a, input logic [7:0] exp);
    st_rd_q.push_back(exp);
    st_cpu_sel = 1'b1; st_cpu_we = 1'b0; st_cpu_addr = a;
    tick();
    st_cpu_sel = 1'b0;
  endtask

  // One display line: n slots under de, then tail slots with de low,
  // of which the first tail_reqs are expected to produce a request.
  task automatic line(input int n, input logic [20:0] start,
                      input int tail, input int tail_reqs, input logic [20:0] tail_start);
    de = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(start + 21'(i));
      fetch = 1'b1; tick();
      fetch = 1'b0; tick();
    end
    de = 1'b0;
    tick();
    for (int j = 0; j < tail; j++) begin
      if (j < tail_reqs) addr_q.push_back(tail_start + 21'(j));
      fetch = 1'b1; tick();
      fetch = 1'b0; tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fetch = 1'b0; de = 1'b0; vsync_n = 1'b1;
    cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    st_vsync_n = 1'b1; st_cpu_sel = 1'b0; st_cpu_we = 1'b0; st_cpu_addr = '0; st_cpu_din = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("reset_vid_addr", {11'd0, vid_addr}, 32'h0);
    check("reset_vid_req", {31'd0, vid_req}, 32'h0);
    rd(5'h00, 8'h00); rd(5'h01, 8'h00); rd(5'h02, 8'h00); rd(5'h03, 8'h00);
    rd(5'h04, 8'h00); rd(5'h06, 8'h00); rd(5'h07, 8'h00); rd(5'h12, 8'h00);
    rd(5'h05, 8'hFF); rd(5'h1F, 8'hFF);

    // Base 0x078000 and frame reload
    wr(5'h00, 8'h07); wr(5'h01, 8'h80); wr(5'h06, 8'h00);
    vsync_n = 1'b0; tick(); vsync_n = 1'b1; tick();
    rd(5'h02, 8'h07); rd(5'h03, 8'h80); rd(5'h04, 8'h00);
    rd(5'h00, 8'h07); rd(5'h01, 8'h80);

    // 80-word line, no line offset: 0x078000..0x07809E, ends at 0x0780A0
    line(80, 21'h03C000, 0, 0, 21'h0);
    rd(5'h02, 8'h07); rd(5'h03, 8'h80); rd(5'h04, 8'hA0);

    // linewid=4: empty de pulse adds 8 bytes, then next line starts at 0x0780A8
    wr(5'h07, 8'h04);
    line(0, 21'h0, 0, 0, 21'h0);
    rd(5'h04, 8'hA8); rd(5'h07, 8'h04);
    line(80, 21'h03C054, 0, 0, 21'h0);
    rd(5'h03, 8'h81); rd(5'h04, 8'h50);

    // hscroll=5, linewid=0: 81 requests, +0xA2 -> 0x0781F2; second tail slot idle
    wr(5'h07, 8'h00); wr(5'h12, 8'h05);
    rd(5'h12, 8'h05);
    line(80, 21'h03C0A8, 2, 1, 21'h03C0F8);
    rd(5'h02, 8'h07); rd(5'h03, 8'h81); rd(5'h04, 8'hF2);

    // vsync fall + fetch with de in one clk: request at old address, counter = base
    addr_q.push_back(21'h03C0F9);
    de = 1'b1; fetch = 1'b1; vsync_n = 1'b0; tick();
    de = 1'b0; fetch = 1'b0; vsync_n = 1'b1; tick();
    fetch = 1'b1; tick(); fetch = 1'b0; tick();
    rd(5'h02, 8'h07); rd(5'h03, 8'h80); rd(5'h04, 8'h00);

    // Counter byte write beats the increment; prefetch then fetches at 0x078020
    addr_q.push_back(21'h03C000);
    de = 1'b1; fetch = 1'b1; cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h04; cpu_din = 8'h20;
    tick();
    de = 1'b0; fetch = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0;
    tick();
    addr_q.push_back(21'h03C010);
    fetch = 1'b1; tick(); fetch = 1'b0; tick();
    rd(5'h04, 8'h22); rd(5'h03, 8'h80);

    // Reset in the middle of a line
    de = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      addr_q.push_back(21'h03C011 + 21'(i));
      fetch = 1'b1; tick();
      fetch = 1'b0; tick();
    end
    fetch = 1'b1; reset = 1'b1;
    #1;
    check("midline_reset_vid_req", {31'd0, vid_req}, 32'h0);
    check("midline_reset_vid_addr", {11'd0, vid_addr}, 32'h0);
    tick();
    de = 1'b0; fetch = 1'b0; tick();
    reset = 1'b0; tick();
    rd(5'h00, 8'h00); rd(5'h01, 8'h00); rd(5'h02, 8'h00); rd(5'h03, 8'h00);
    rd(5'h04, 8'h00); rd(5'h06, 8'h00); rd(5'h07, 8'h00); rd(5'h12, 8'h00);

    // Plain ST instance: STE-only registers and counter writes are ignored
    st_wr(5'h00, 8'h07); st_wr(5'h01, 8'h80);
    st_vsync_n = 1'b0; tick(); st_vsync_n = 1'b1; tick();
    st_rd(5'h02, 8'h07); st_rd(5'h03, 8'h80); st_rd(5'h04, 8'h00);
    st_wr(5'h06, 8'h55); st_rd(5'h06, 8'h00);
    st_wr(5'h04, 8'h12); st_rd(5'h04, 8'h00); st_rd(5'h03, 8'h80);
    st_wr(5'h07, 8'h33); st_rd(5'h07, 8'h00);
    st_wr(5'h12, 8'h05); st_rd(5'h12, 8'h00);
    st_rd(5'h00, 8'h07); st_rd(5'h01, 8'h80);

    tick(); tick();
    check("ste_req_queue_drained", addr_q.size(), 32'h0);
    check("ste_read_queue_drained", rd_q.size(), 32'h0);
    check("st_read_queue_drained", st_rd_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
